// File: rtl/imem_boot_loader.sv
// -----------------------------------------------------------------------------
// imem_boot_loader
//
// Instruction-memory stage that sits directly in front of the single-cycle
// core. It owns the instruction RAM, fetches Instr from the core's PC, and keeps
// the core in reset until a complete program has been streamed in.
//
// The program arrives as a little-endian byte stream over a valid/ready
// handshake, with four bytes per 32-bit word. A clean stream ends with
// load_last on the fourth byte of a word. When that happens the loader moves to
// RUN and releases core_reset. A malformed stream moves the loader to ERROR and
// the core stays in reset. An early load_last or a memory overflow counts as
// malformed. RUN and ERROR are left only through reset.
//
// Optional build macro:
//   IMEM_CHECKSUM_EN - the final stream word is a 32-bit checksum. It equals
//                      the mod-2^32 sum of all data words. It is compared, not
//                      stored, and a mismatch leads to ERROR.
//
// Ports:
//   clk         system clock, all state on rising edge
//   reset       synchronous, active-high reset
//   load_valid  byte present on load_byte
//   load_ready  loader accepts a byte this cycle (LOAD state only)
//   load_byte   program byte, little-endian within each word
//   load_last   marks the final byte of the stream
//   PC          fetch address from the core (byte address, word aligned)
//   Instr       instruction to the core (NOP_INSTR while core is held)
//   core_reset  active-high reset to the core
//   load_done   program loaded, core running
//   load_error  malformed stream detected
//   word_count  number of words written to memory
// -----------------------------------------------------------------------------
module imem_boot_loader #(
    parameter int          ADDR_WIDTH = 6,
    parameter logic [31:0] NOP_INSTR  = 32'h00000013
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [7:0]            load_byte,
    input  logic                  load_last,
    input  logic [31:0]           PC,
    output logic [31:0]           Instr,
    output logic                  core_reset,
    output logic                  load_done,
    output logic                  load_error,
    output logic [ADDR_WIDTH:0]   word_count
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // word_count value that means every memory location has been filled.
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    state_t                state_reg, state_next;
    logic [1:0]            byte_idx_reg, byte_idx_next;
    // Only the low three bytes need to be held. The fourth byte arrives on the
    // cycle the word completes and is used directly.
    logic [23:0]           asm_reg, asm_next;
    logic [ADDR_WIDTH:0]   word_count_reg, word_count_next;

    logic [31:0]           mem [DEPTH];
    logic                  mem_we;
    logic [31:0]           word_full;
    logic                  xfer;
    logic                  mem_full;

`ifdef IMEM_CHECKSUM_EN
    logic [31:0]           sum_reg, sum_next;
`endif

    assign xfer      = load_valid && (state_reg == ST_LOAD);
    assign word_full = {load_byte, asm_reg};
    assign mem_full  = (word_count_reg == FULL_COUNT);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_LOAD;
            byte_idx_reg   <= 2'd0;
            asm_reg        <= 24'd0;
            word_count_reg <= '0;
`ifdef IMEM_CHECKSUM_EN
            sum_reg        <= 32'd0;
`endif
        end else begin
            state_reg      <= state_next;
            byte_idx_reg   <= byte_idx_next;
            asm_reg        <= asm_next;
            word_count_reg <= word_count_next;
`ifdef IMEM_CHECKSUM_EN
            sum_reg        <= sum_next;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic: byte assembly, word commit, terminal-state decisions
    // -------------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        byte_idx_next   = byte_idx_reg;
        asm_next        = asm_reg;
        word_count_next = word_count_reg;
        mem_we          = 1'b0;
`ifdef IMEM_CHECKSUM_EN
        sum_next        = sum_reg;
`endif

        if (xfer) begin
            byte_idx_next = byte_idx_reg + 2'd1;

            if (byte_idx_reg != 2'd3) begin
                // Mid-word byte. A last marker here means a truncated word,
                // so the partial word is dropped and nothing is written.
                if (load_last) begin
                    state_next = ST_ERROR;
                end else begin
                    case (byte_idx_reg)
                        2'd0:    asm_next[7:0]   = load_byte;
                        2'd1:    asm_next[15:8]  = load_byte;
                        2'd2:    asm_next[23:16] = load_byte;
                        default: asm_next        = asm_reg;
                    endcase
                end
            end else begin
                // Fourth byte: the word is complete this cycle.
                asm_next = 24'd0;
`ifdef IMEM_CHECKSUM_EN
                if (load_last) begin
                    // The checksum word is never stored, so a full memory
                    // does not block it.
                    state_next = (word_full == sum_reg) ? ST_RUN : ST_ERROR;
                end else if (mem_full) begin
                    state_next = ST_ERROR;
                end else begin
                    mem_we          = 1'b1;
                    word_count_next = word_count_reg + 1'b1;
                    sum_next        = sum_reg + word_full;
                end
`else
                if (mem_full) begin
                    state_next = ST_ERROR;
                end else begin
                    mem_we          = 1'b1;
                    word_count_next = word_count_reg + 1'b1;
                    if (load_last) begin
                        state_next = ST_RUN;
                    end
                end
`endif
            end
        end
    end

    // -------------------------------------------------------------------------
    // Instruction RAM. The write port is used only in LOAD. The read port is
    // asynchronous because the single-cycle core expects Instr in the same
    // cycle as PC. Reads and writes never overlap, because Instr is forced to
    // NOP while loading. Contents deliberately survive reset.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[word_count_reg[ADDR_WIDTH-1:0]] <= word_full;
        end
    end

    // PC[1:0] and the bits above the memory index are ignored, so fetch
    // addresses wrap around the memory.
    logic [ADDR_WIDTH-1:0] fetch_idx;
    logic                  unused_pc_bits;

    assign fetch_idx      = PC[ADDR_WIDTH+1:2];
    assign unused_pc_bits = &{1'b0, PC[31:ADDR_WIDTH+2], PC[1:0]};

    // -------------------------------------------------------------------------
    // Outputs are decoded from the state register. As a result, core_reset and
    // load_done change on the edge after the final handshake.
    // -------------------------------------------------------------------------
    assign load_ready = (state_reg == ST_LOAD);
    assign core_reset = (state_reg != ST_RUN);
    assign load_done  = (state_reg == ST_RUN);
    assign load_error = (state_reg == ST_ERROR);
    assign word_count = word_count_reg;
    assign Instr      = core_reset ? NOP_INSTR : mem[fetch_idx];

endmodule

// File: tb/tb_imem_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_boot_loader
//
// Table-driven bench for imem_boot_loader, built with ADDR_WIDTH=2 (4 words).
// Each vector drives the inputs for one clock. It checks the outputs before the
// following rising edge, so the expected values describe the state that the
// previous edges left behind. Vectors with chk=0 (reset cycles) only drive.
// -----------------------------------------------------------------------------
module tb_imem_boot_loader;

    localparam int          AW  = 2;
    localparam logic [31:0] NOP = 32'h00000013;

    logic          clk;
    logic          reset;
    logic          load_valid;
    logic          load_ready;
    logic [7:0]    load_byte;
    logic          load_last;
    logic [31:0]   pc;
    logic [31:0]   instr;
    logic          core_reset;
    logic          load_done;
    logic          load_error;
    logic [AW:0]   word_count;

    imem_boot_loader #(
        .ADDR_WIDTH (AW),
        .NOP_INSTR  (NOP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_byte  (load_byte),
        .load_last  (load_last),
        .PC         (pc),
        .Instr      (instr),
        .core_reset (core_reset),
        .load_done  (load_done),
        .load_error (load_error),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        vld;
        logic [7:0]  b;
        logic        lst;
        logic [31:0] pc;
        bit          chk;
        logic        rdy;
        logic        cr;
        logic        dn;
        logic        er;
        logic [AW:0] wc;
        logic [31:0] ins;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Program words used by the default (no checksum) tests.
    localparam logic [31:0] A0 = 32'h00100093;
    localparam logic [31:0] A1 = 32'h00200113;
    localparam logic [31:0] A2 = 32'h002081b3;
    localparam logic [31:0] A3 = 32'h0000006f;

    // ---------------- table builders ----------------
    task automatic add(input logic rst, input logic vld, input logic [7:0] b,
                       input logic lst, input logic [31:0] p, input bit chk,
                       input logic rdy, input logic cr, input logic dn,
                       input logic er, input logic [AW:0] wc,
                       input logic [31:0] ins);
        vec_t v;
        v.rst = rst; v.vld = vld; v.b = b; v.lst = lst; v.pc = p; v.chk = chk;
        v.rdy = rdy; v.cr = cr; v.dn = dn; v.er = er; v.wc = wc; v.ins = ins;
        tbl.push_back(v);
    endtask

    task automatic add_rst();
        add(1'b1, 1'b0, 8'h00, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 32'd0);
    endtask

    // LOAD state expected: ready, core held, Instr is NOP for any PC.
    task automatic add_load(input logic vld, input logic [7:0] b,
                            input logic lst, input logic [AW:0] wc);
        add(1'b0, vld, b, lst, 32'h0000_0008, 1'b1,
            1'b1, 1'b1, 1'b0, 1'b0, wc, NOP);
    endtask

    task automatic add_run(input logic [31:0] p, input logic [AW:0] wc,
                           input logic [31:0] ins);
        add(1'b0, 1'b0, 8'h00, 1'b0, p, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, wc, ins);
    endtask

    task automatic add_err(input logic vld, input logic [7:0] b, input logic [AW:0] wc);
        add(1'b0, vld, b, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, wc, NOP);
    endtask

    // Four bytes of one word, LSB first, with an optional idle gap after each.
    // A gap is never placed after a byte that carries load_last.
    task automatic add_word(input logic [31:0] w, input logic lst,
                            input logic [AW:0] wc, input bit gaps);
        logic [AW:0] wc_after;
        for (int k = 0; k < 4; k++) begin
            add_load(1'b1, w[8*k +: 8], lst && (k == 3), wc);
            if (gaps && !(lst && k == 3)) begin
                wc_after = (k == 3) ? wc + 1'b1 : wc;
                add_load(1'b0, 8'hff, 1'b0, wc_after);
            end
        end
    endtask

    task automatic build_table();
`ifdef IMEM_CHECKSUM_EN
        // Good checksum: 1 + 2 = 3.
        add_rst();
        add_load(1'b0, 8'h00, 1'b0, 3'd0);
        add_word(32'd1, 1'b0, 3'd0, 1'b0);
        add_word(32'd2, 1'b0, 3'd1, 1'b0);
        add_word(32'd3, 1'b1, 3'd2, 1'b0);
        add_run(32'd0, 3'd2, 32'd1);
        add_run(32'd4, 3'd2, 32'd2);
        // Bad checksum.
        add_rst();
        add_load(1'b0, 8'h00, 1'b0, 3'd0);
        add_word(32'd1, 1'b0, 3'd0, 1'b0);
        add_word(32'd2, 1'b0, 3'd1, 1'b0);
        add_word(32'd4, 1'b1, 3'd2, 1'b0);
        add_err(1'b0, 8'h00, 3'd2);
        // Memory full, but the checksum word is still accepted.
        add_rst();
        add_load(1'b0, 8'h00, 1'b0, 3'd0);
        add_word(32'd1, 1'b0, 3'd0, 1'b0);
        add_word(32'd2, 1'b0, 3'd1, 1'b0);
        add_word(32'd3, 1'b0, 3'd2, 1'b0);
        add_word(32'd4, 1'b0, 3'd3, 1'b0);
        add_word(32'd10, 1'b1, 3'd4, 1'b0);
        add_run(32'd12, 3'd4, 32'd4);
`else
        // Basic single-word load.
        add_rst();
        add_load(1'b0, 8'h00, 1'b0, 3'd0);
        add_word(32'h00100513, 1'b1, 3'd0, 1'b0);
        add_run(32'd0, 3'd1, 32'h00100513);
        add_run(32'd16, 3'd1, 32'h00100513);
        // Gapped valid: 2 words, junk bytes on low-valid cycles.
        add_rst();
        add_load(1'b0, 8'h00, 1'b0, 3'd0);
        add_word(A0, 1'b0, 3'd0, 1'b1);
        add_word(A1, 1'b1, 3'd1, 1'b1);
        add_run(32'd0, 3'd2, A0);
        add_run(32'd4, 3'd2, A1);
        // Early last on the 2nd byte.
        add_rst();
        add_load(1'b0, 8'h00, 1'b0, 3'd0);
        add_load(1'b1, 8'h01, 1'b0, 3'd0);
        add_load(1'b1, 8'h02, 1'b1, 3'd0);
        add_err(1'b1, 8'h03, 3'd0);
        add_err(1'b0, 8'h00, 3'd0);
        // Reset mid-word, then a fresh word built only from the new bytes.
        add_rst();
        add_load(1'b1, 8'haa, 1'b0, 3'd0);
        add_load(1'b1, 8'hbb, 1'b0, 3'd0);
        add_rst();
        add_load(1'b0, 8'h00, 1'b0, 3'd0);
        add_word(32'h00000537, 1'b1, 3'd0, 1'b0);
        add_run(32'd0, 3'd1, 32'h00000537);
        // Overflow: a 5th word into a 4-word memory.
        add_rst();
        add_load(1'b0, 8'h00, 1'b0, 3'd0);
        add_word(32'h11111111, 1'b0, 3'd0, 1'b0);
        add_word(32'h22222222, 1'b0, 3'd1, 1'b0);
        add_word(32'h33333333, 1'b0, 3'd2, 1'b0);
        add_word(32'h44444444, 1'b0, 3'd3, 1'b0);
        add_word(32'h55555555, 1'b0, 3'd4, 1'b0);
        add_err(1'b0, 8'h00, 3'd4);
        // Good 4-word load, then check that fetch addresses wrap.
        add_rst();
        add_load(1'b0, 8'h00, 1'b0, 3'd0);
        add_word(A0, 1'b0, 3'd0, 1'b0);
        add_word(A1, 1'b0, 3'd1, 1'b0);
        add_word(A2, 1'b0, 3'd2, 1'b0);
        add_word(A3, 1'b1, 3'd3, 1'b0);
        add_run(32'd0,  3'd4, A0);
        add_run(32'd4,  3'd4, A1);
        add_run(32'd8,  3'd4, A2);
        add_run(32'd12, 3'd4, A3);
        add_run(32'd16, 3'd4, A0);
        add_run(32'd23, 3'd4, A1);
`endif
    endtask

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h", name, got, exp);
        end else begin
            $display("ok   %s = %h", name, got);
        end
    endtask

    initial begin
        logic [AW+36:0] got_v;
        logic [AW+36:0] exp_v;
        logic [31:0]    hold_exp;

        reset      = 1'b1;
        load_valid = 1'b0;
        load_byte  = 8'h00;
        load_last  = 1'b0;
        pc         = 32'd0;

        build_table();

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            reset      = tbl[i].rst;
            load_valid = tbl[i].vld;
            load_byte  = tbl[i].b;
            load_last  = tbl[i].lst;
            pc         = tbl[i].pc;
            #1;
            if (tbl[i].chk) begin
                got_v = {load_ready, core_reset, load_done, load_error, word_count, instr};
                exp_v = {tbl[i].rdy, tbl[i].cr, tbl[i].dn, tbl[i].er, tbl[i].wc, tbl[i].ins};
                n_vec++;
                if (got_v !== exp_v) begin
                    n_bad++;
                    $display("FAIL vec%0d rdy/cr/dn/er/wc/instr got=%b%b%b%b/%0d/%h want=%b%b%b%b/%0d/%h",
                             i, load_ready, core_reset, load_done, load_error, word_count, instr,
                             tbl[i].rdy, tbl[i].cr, tbl[i].dn, tbl[i].er, tbl[i].wc, tbl[i].ins);
                end else begin
                    $display("vec%0d ok: vld=%b byte=%h last=%b pc=%0d -> wc=%0d instr=%h",
                             i, tbl[i].vld, tbl[i].b, tbl[i].lst, tbl[i].pc, word_count, instr);
                end
            end
        end

        // Hand-written sequence: valid held high with last while in RUN must
        // be ignored for several cycles, and memory and the count stay unchanged.
`ifdef IMEM_CHECKSUM_EN
        hold_exp = 32'd3;
`else
        hold_exp = A2;
`endif
        @(negedge clk);
        reset      = 1'b0;
        load_valid = 1'b1;
        load_byte  = 8'h5a;
        load_last  = 1'b1;
        pc         = 32'd8;
        repeat (3) @(negedge clk);
        #1;
        check("hold_ready", {31'd0, load_ready}, 32'd0);
        check("hold_done",  {31'd0, load_done},  32'd1);
        check("hold_wc",    {{(31-AW){1'b0}}, word_count}, 32'd4);
        check("hold_instr", instr, hold_exp);

        // Hand-written sequence: reset from RUN returns to the LOAD outputs.
        @(negedge clk);
        reset      = 1'b1;
        load_valid = 1'b0;
        load_last  = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_ready", {31'd0, load_ready}, 32'd1);
        check("rst_core",  {31'd0, core_reset}, 32'd1);
        check("rst_wc",    {{(31-AW){1'b0}}, word_count}, 32'd0);
        check("rst_instr", instr, NOP);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Instruction-memory stage directly upstream of the single-cycle core: owns the instruction RAM, drives the core's `Instr` from its `PC`, and holds the core in reset until a program is loaded.
- Program arrives as a byte stream over a valid/ready handshake, little-endian, one 32-bit word per 4 bytes.
- After a clean load it releases `core_reset`. On a malformed stream it parks in an error state with the core still held.

Parameters:
- ADDR_WIDTH, 6, word-address width; memory depth DEPTH = 2**ADDR_WIDTH words.
- NOP_INSTR, 32'h00000013, value driven on `Instr` while the core is held in reset.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- load_valid  input  1  byte present on `load_byte`
- load_ready  output  1  loader accepts a byte this cycle
- load_byte  input  8  program byte, little-endian within each word
- load_last  input  1  qualifies the final byte of the stream
- PC  input  32  fetch address from the core
- Instr  output  32  instruction to the core
- core_reset  output  1  reset to the core, active-high
- load_done  output  1  program loaded, core running
- load_error  output  1  malformed stream detected
- word_count  output  ADDR_WIDTH+1  words written to memory

Behaviour:
- One clock, `clk`. Reset is synchronous and active-high on `reset`; all state is updated on the rising edge of `clk`.
- States: LOAD, RUN, ERROR.
- Reset (from any state, including mid-word): state=LOAD, byte_idx=0, word_count=0, assembly register=0, core_reset=1, load_done=0, load_error=0. Memory contents are NOT cleared.
- Outputs per state:
  - load_ready=1 only in LOAD.
  - core_reset=1 in LOAD and ERROR, 0 in RUN.
  - load_done=1 only in RUN.
  - load_error=1 only in ERROR.
- Handshake: a byte transfers on a cycle where load_valid && load_ready. No transfer means no state change. load_valid may be held across non-ready cycles; load_byte must stay stable while load_valid=1.
- Byte assembly: byte_idx 0..3 places the byte in bits [8*idx+7 : 8*idx]; byte_idx increments mod 4 on each transfer.
- A word completes on a transfer with byte_idx=3:
  - Completed word = {load_byte, bits[23:0]}.
  - It is written to mem[word_count[ADDR_WIDTH-1:0]] on that edge and word_count increments.
- load_last on a transfer:
  - With byte_idx=3: word completes as above; next state=RUN. core_reset falls and load_done rises on the edge following the final handshake (1-cycle registered latency).
  - With byte_idx≠3: next state=ERROR; the partial word is discarded, nothing is written.
- Overflow: a word completing while word_count==DEPTH goes to ERROR with no write, whether or not load_last is set.
- RUN and ERROR are terminal until reset; load_ready=0 in both.
- Fetch:
  - Instr = mem[PC[ADDR_WIDTH+1:2]], combinational read, same cycle.
  - PC[1:0] and bits above ADDR_WIDTH+1 are ignored, so addresses wrap.
  - When core_reset=1, Instr=NOP_INSTR regardless of PC.
- Write/read of the same address in one cycle cannot occur, because the core is held in reset during LOAD.

Optional Feature:
- Macro: IMEM_CHECKSUM_EN.
- Defined:
  - The final stream word (the one ending with load_last) is a checksum and is NOT written to memory; word_count excludes it.
  - A 32-bit running sum (mod 2^32) accumulates every written word and resets to 0 on reset.
  - Checksum equals sum → RUN. Mismatch → ERROR.
  - Overflow applies only to non-last words; the checksum word is accepted even when word_count==DEPTH.
- Not defined: the last word is program data and is written as normal; no sum logic exists.

Test Plan:
- Basic load: bytes 13,05,10,00 with last on the 4th byte → mem[0]=32'h00100513, word_count=1; next cycle core_reset=0, load_done=1; PC=0 gives Instr=32'h00100513.
- Backpressure/gaps: 8 bytes with load_valid toggled 1,0,1… and load_last on byte 8 → exactly 2 words written in order; core_reset deasserts 1 cycle after the 8th handshake; no transfer occurs on low-valid cycles.
- Early last: load_last on the 2nd byte → ERROR, load_error=1, core_reset stays 1, load_ready=0, word_count=0.
- Overflow (ADDR_WIDTH=2):
  - 4 full words without last, then a 5th word → ERROR on the 5th word's 4th byte, word_count=4, mem unchanged at addr 0.
  - A PC wrap check after a good 4-word load: PC=16 gives Instr=mem[0].
- Reset mid-word: after 2 bytes, assert reset → byte_idx=0, state=LOAD; a subsequent 4-byte load writes mem[0] with only the new bytes.
- IMEM_CHECKSUM_EN:
  - Words 1 and 2 followed by checksum 3 → RUN, word_count=2.
  - Same words with checksum 4 → ERROR, load_error=1.
